mem_lsu: RTL and testbench

Parametrised load/store unit that replaces the single-access memory execute stage. It accepts one memory op per cycle from decode/ALU over a valid/ready handshake and drives an external memory bus with a req/gnt handshake, per-lane byte enables and lane-replicated write data. It tracks up to DEPTH outstanding loads in an in-order FIFO. It aligns and sign-/zero-extends returning load data before handing it to writeback. Misaligned accesses are trapped locally and never reach the bus.

---
 rtl/mem_lsu.sv | 218 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one memory op per cycle, drives a req/gnt memory bus,
// tracks outstanding loads in an in-order FIFO and aligns/extends returning data.
module mem_lsu #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DEPTH     = 4,
    parameter bit          ALIGN_CHK = 1'b1,
    parameter logic [3:0]  OPCAT_LD  = 4'h1,
    parameter logic [3:0]  OPCAT_ST  = 4'h2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [5:0]    opcode_i,
    input  logic          signed_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          bus_req_o,
    input  logic          bus_gnt_i,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [3:0]    bus_be_o,
    output logic [31:0]   bus_wdata_o,
    input  logic          bus_rvalid_i,
    input  logic [31:0]   bus_rdata_i,
    output logic          ld_valid_o,
    output logic [31:0]   ld_data_o,
    output logic          exc_valid_o,
    output logic          exc_st_o,
    output logic [AW-1:0] exc_addr_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] SC_BYTE = 2'b00;
    localparam logic [1:0] SC_HALF = 2'b01;
    localparam logic [1:0] SC_ILL  = 2'b10;
    localparam logic [1:0] SC_WORD = 2'b11;

    typedef struct packed {
        logic [1:0] scope;
        logic       sgn;
        logic [1:0] off;
    } entry_t;

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;

    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          ld_valid_q, ld_valid_d;
    logic [31:0]   ld_data_q, ld_data_d;
    logic          exc_valid_q, exc_valid_d;
    logic          exc_st_q, exc_st_d;
    logic [AW-1:0] exc_addr_q, exc_addr_d;
    logic          err_q, err_d;

    logic [3:0]    opcat;
    logic [1:0]    scope;
    logic          is_ld, is_st, misaligned, trap;
    logic [1:0]    eff_off;
    logic          in_ready, accept, issue, push, pop;
    entry_t        head;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld_res;

    always_comb begin
        opcat      = opcode_i[5:2];
        scope      = opcode_i[1:0];
        is_ld      = (opcat == OPCAT_LD);
        is_st      = (opcat == OPCAT_ST);
        misaligned = ((scope == SC_HALF) && addr_i[0]) ||
                     ((scope == SC_WORD) && (addr_i[1:0] != 2'b00));
        trap       = (is_ld || is_st) && ((scope == SC_ILL) || (ALIGN_CHK && misaligned));
        // Without alignment checking a misaligned access is issued at offset 0.
        eff_off    = misaligned ? 2'b00 : addr_i[1:0];
        in_ready   = (!req_q || bus_gnt_i) && (count_q < FULL);
        accept     = in_valid_i && in_ready;
        issue      = accept && (is_ld || is_st) && !trap;
        push       = issue && is_ld;
        pop        = bus_rvalid_i && (count_q != '0);
    end

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (req_q && bus_gnt_i) begin
            req_d = 1'b0;
        end
        if (issue) begin
            req_d  = 1'b1;
            we_d   = is_st;
            addr_d = {addr_i[AW-1:2], 2'b00};
            case (scope)
                SC_BYTE: be_d = 4'b0001 << eff_off;
                SC_HALF: be_d = 4'b0011 << eff_off;
                default: be_d = 4'b1111;
            endcase
            wdata_d = '0;
            if (is_st) begin
                case (scope)
                    SC_BYTE: wdata_d = {4{wdata_i[7:0]}};
                    SC_HALF: wdata_d = {2{wdata_i[15:0]}};
                    default: wdata_d = wdata_i;
                endcase
            end
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = entry_t'({scope, signed_i, eff_off});
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        head = fifo_q[rd_ptr_q];
        case (head.off)
            2'd0:    byte_sel = bus_rdata_i[7:0];
            2'd1:    byte_sel = bus_rdata_i[15:8];
            2'd2:    byte_sel = bus_rdata_i[23:16];
            default: byte_sel = bus_rdata_i[31:24];
        endcase
        half_sel = head.off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (head.scope)
            SC_BYTE: ld_res = {{24{head.sgn & byte_sel[7]}}, byte_sel};
            SC_HALF: ld_res = {{16{head.sgn & half_sel[15]}}, half_sel};
            default: ld_res = bus_rdata_i;
        endcase

        ld_valid_d  = pop;
        ld_data_d   = pop ? ld_res : ld_data_q;
        exc_valid_d = accept && trap;
        exc_st_d    = (accept && trap) ? is_st : exc_st_q;
        exc_addr_d  = (accept && trap) ? addr_i : exc_addr_q;
        // A response with nothing outstanding is a protocol error that stays visible.
        err_d       = err_q || (bus_rvalid_i && (count_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_st_q    <= 1'b0;
            exc_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            exc_valid_q <= exc_valid_d;
            exc_st_q    <= exc_st_d;
            exc_addr_q  <= exc_addr_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign ld_valid_o  = ld_valid_q;
    assign ld_data_o   = ld_data_q;
    assign exc_valid_o = exc_valid_q;
    assign exc_st_o    = exc_st_q;
    assign exc_addr_o  = exc_addr_q;
    assign busy_o      = req_q || (count_q != '0);
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the load/store unit.
module tb_mem_lsu;

   localparam int AW = 32;
   localparam int DEPTH = 4;
   localparam logic [3:0] OPCAT_LD = 4'h1;
   localparam logic [3:0] OPCAT_ST = 4'h2;

   logic          clk;
   logic          rst;
   logic          inValid;
   logic          inReady;
   logic [5:0]    opcode;
   logic          signedLd;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          busReq;
   logic          busGnt;
   logic          busWe;
   logic [AW-1:0] busAddr;
   logic [3:0]    busBe;
   logic [31:0]   busWdata;
   logic          busRvalid;
   logic [31:0]   busRdata;
   logic          ldValid;
   logic [31:0]   ldData;
   logic          excValid;
   logic          excSt;
   logic [AW-1:0] excAddr;
   logic          busy;
   logic          err;

   int checkCount = 0;
   int errorCount = 0;

   // Behavioural model state: the pending bus request, the queue of outstanding
   // loads (scope, sign, offset packed as 5 bits) and the expected result registers.
   bit          mReq;
   bit          mWe;
   logic [31:0] mAddr;
   logic [3:0]  mBe;
   logic [31:0] mWdata;
   logic [4:0]  mQ[$];
   bit          expLdValid;
   logic [31:0] expLdData;
   bit          expExcValid;
   bit          expExcSt;
   logic [31:0] expExcAddr;
   bit          mErr;

   mem_lsu #(
      .AW(AW),
      .DEPTH(DEPTH),
      .ALIGN_CHK(1'b1),
      .OPCAT_LD(OPCAT_LD),
      .OPCAT_ST(OPCAT_ST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid_i(inValid),
      .in_ready_o(inReady),
      .opcode_i(opcode),
      .signed_i(signedLd),
      .addr_i(addr),
      .wdata_i(wdata),
      .bus_req_o(busReq),
      .bus_gnt_i(busGnt),
      .bus_we_o(busWe),
      .bus_addr_o(busAddr),
      .bus_be_o(busBe),
      .bus_wdata_o(busWdata),
      .bus_rvalid_i(busRvalid),
      .bus_rdata_i(busRdata),
      .ld_valid_o(ldValid),
      .ld_data_o(ldData),
      .exc_valid_o(excValid),
      .exc_st_o(excSt),
      .exc_addr_o(excAddr),
      .busy_o(busy),
      .err_o(err)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Expected load result from the raw word using plain shifts and masks.
   function automatic logic [31:0] loadResult(input logic [31:0] rd, input logic [4:0] e);
      logic [31:0] v;
      int sc;
      int off;
      sc = int'(e[4:3]);
      off = int'(e[1:0]);
      if (sc == 0) begin
         v = (rd >> (8 * off)) & 32'hFF;
         if (e[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sc == 1) begin
         v = (rd >> (8 * off)) & 32'hFFFF;
         if (e[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [3:0] byteEnables(input logic [1:0] sc, input logic [1:0] off);
      if (sc == 2'b00) return 4'(1 << off);
      if (sc == 2'b01) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] laneData(input logic [1:0] sc, input logic [31:0] wd);
      if (sc == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
      if (sc == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [5:0] mkOp(input logic [3:0] cat, input logic [1:0] sc);
      return {cat, sc};
   endfunction

   // Advance the model by one clock edge given this cycle's inputs.
   task automatic modelStep(input bit acc, input logic [5:0] op, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic g, input logic rv, input logic [31:0] rd);
      logic [4:0] e;
      logic [1:0] sc;
      bit isLd;
      bit isSt;
      bit bad;
      sc = op[1:0];
      isLd = (op[5:2] == OPCAT_LD);
      isSt = (op[5:2] == OPCAT_ST);
      expLdValid = 1'b0;
      expExcValid = 1'b0;
      if (rv) begin
         if (mQ.size() > 0) begin
            e = mQ.pop_front();
            expLdValid = 1'b1;
            expLdData = loadResult(rd, e);
         end else begin
            mErr = 1'b1;
         end
      end
      if (mReq && g) mReq = 1'b0;
      if (acc && (isLd || isSt)) begin
         bad = (sc == 2'b10) || (sc == 2'b01 && a[0]) || (sc == 2'b11 && a[1:0] != 2'b00);
         if (bad) begin
            expExcValid = 1'b1;
            expExcSt = isSt;
            expExcAddr = a;
         end else begin
            mReq = 1'b1;
            mWe = isSt;
            mAddr = a & 32'hFFFF_FFFC;
            mBe = byteEnables(sc, a[1:0]);
            mWdata = isSt ? laneData(sc, wd) : 32'h0;
            if (isLd) mQ.push_back({sc, sg, a[1:0]});
         end
      end
   endtask

   task automatic modelReset();
      mReq = 0; mWe = 0; mAddr = 0; mBe = 0; mWdata = 0;
      mQ.delete();
      expLdValid = 0; expLdData = 0; expExcValid = 0; expExcSt = 0; expExcAddr = 0;
      mErr = 0;
   endtask

   // Compare all registered outputs against the model after an edge.
   task automatic checkAll();
      checkOutput("bus_req", busReq, mReq);
      if (mReq) begin
         checkOutput("bus_we", busWe, mWe);
         checkOutput("bus_addr", busAddr, mAddr);
         checkOutput("bus_be", busBe, mBe);
         checkOutput("bus_wdata", busWdata, mWdata);
      end
      checkOutput("ld_valid", ldValid, expLdValid);
      checkOutput("ld_data", ldData, expLdData);
      checkOutput("exc_valid", excValid, expExcValid);
      checkOutput("exc_st", excSt, expExcSt);
      checkOutput("exc_addr", excAddr, expExcAddr);
      checkOutput("err", err, mErr);
      checkOutput("busy", busy, (mReq || mQ.size() > 0));
   endtask

   // Drive one cycle of inputs from a negedge, check the combinational ready,
   // step the model across the posedge and check the outputs at the next negedge.
   task automatic applyStimulus(input logic v, input logic [5:0] op, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic g, input logic rv, input logic [31:0] rd,
                                output bit accepted);
      bit expReady;
      inValid = v; opcode = op; signedLd = sg; addr = a; wdata = wd;
      busGnt = g; busRvalid = rv; busRdata = rd;
      #1;
      expReady = (!mReq || g) && (mQ.size() < DEPTH);
      checkOutput("in_ready", inReady, expReady);
      accepted = v && inReady;
      modelStep(v && expReady, op, sg, a, wd, g, rv, rd);
      @(posedge clk);
      @(negedge clk);
      checkAll();
   endtask

   task automatic idleCycle(input logic g);
      bit acc;
      applyStimulus(1'b0, 6'h0, 1'b0, 32'h0, 32'h0, g, 1'b0, 32'h0, acc);
   endtask

   // Assert reset asynchronously between edges and check every output clears.
   task automatic applyReset();
      rst = 1'b1;
      inValid = 0; opcode = 0; signedLd = 0; addr = 0; wdata = 0;
      busGnt = 0; busRvalid = 0; busRdata = 0;
      #1;
      checkOutput("rst_bus_req", busReq, 0);
      checkOutput("rst_bus_we", busWe, 0);
      checkOutput("rst_bus_addr", busAddr, 0);
      checkOutput("rst_bus_be", busBe, 0);
      checkOutput("rst_bus_wdata", busWdata, 0);
      checkOutput("rst_ld_valid", ldValid, 0);
      checkOutput("rst_ld_data", ldData, 0);
      checkOutput("rst_exc_valid", excValid, 0);
      checkOutput("rst_exc_st", excSt, 0);
      checkOutput("rst_exc_addr", excAddr, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err, 0);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkAll();
   endtask

   // Main sequence: directed scenarios, random traffic, error and reset cases.
   initial begin
      bit acc;
      int guard;
      logic [3:0] cat;
      logic [1:0] sc;
      logic [31:0] a;
      rst = 1'b1;
      inValid = 0; opcode = 0; signedLd = 0; addr = 0; wdata = 0;
      busGnt = 0; busRvalid = 0; busRdata = 0;
      modelReset();
      @(negedge clk);
      applyReset();

      // Word store granted in the first request cycle.
      applyStimulus(1, mkOp(OPCAT_ST, 2'b11), 0, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, acc);
      checkOutput("st_word_req", busReq, 1);
      checkOutput("st_word_be", busBe, 4'hF);
      checkOutput("st_word_addr", busAddr, 32'h100);
      checkOutput("st_word_wdata", busWdata, 32'hDEAD_BEEF);
      idleCycle(1);
      checkOutput("st_word_req_drop", busReq, 0);
      checkOutput("st_word_no_ld", ldValid, 0);

      // Signed then unsigned byte load from the top lane.
      applyStimulus(1, mkOp(OPCAT_LD, 2'b00), 1, 32'h103, 0, 0, 0, 0, acc);
      checkOutput("ld_byte_be", busBe, 4'b1000);
      idleCycle(1);
      applyStimulus(0, 6'h0, 0, 0, 0, 0, 1, 32'h80AA_BBCC, acc);
      checkOutput("ld_byte_signed", ldData, 32'hFFFF_FF80);
      applyStimulus(1, mkOp(OPCAT_LD, 2'b00), 0, 32'h103, 0, 0, 0, 0, acc);
      applyStimulus(0, 6'h0, 0, 0, 0, 1, 1, 32'h80AA_BBCC, acc);
      checkOutput("ld_byte_unsigned", ldData, 32'h0000_0080);

      // Half store with a grant delayed three cycles; a second op waits on it.
      applyStimulus(1, mkOp(OPCAT_ST, 2'b01), 0, 32'h202, 32'h0000_1234, 0, 0, 0, acc);
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1, mkOp(OPCAT_ST, 2'b00), 0, 32'h204, 32'h55, 0, 0, 0, acc);
         checkOutput("st_half_stall_accept", acc, 0);
         checkOutput("st_half_addr", busAddr, 32'h200);
         checkOutput("st_half_be", busBe, 4'b1100);
         checkOutput("st_half_wdata", busWdata, 32'h1234_1234);
      end
      applyStimulus(1, mkOp(OPCAT_ST, 2'b00), 0, 32'h204, 32'h55, 1, 0, 0, acc);
      checkOutput("st_half_gnt_accept", acc, 1);
      idleCycle(1);

      // Fill the load FIFO, stall the fifth load, then free a slot with rvalid.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, mkOp(OPCAT_LD, 2'b00), k[0], 32'h300 + k, 0, 1, 0, 0, acc);
      end
      applyStimulus(1, mkOp(OPCAT_LD, 2'b00), 0, 32'h310, 0, 1, 0, 0, acc);
      checkOutput("full_stall", acc, 0);
      applyStimulus(1, mkOp(OPCAT_LD, 2'b00), 0, 32'h310, 0, 1, 1, 32'h4433_2211, acc);
      checkOutput("full_pop_stall", acc, 0);
      checkOutput("full_first_result", ldData, 32'h11);
      applyStimulus(1, mkOp(OPCAT_LD, 2'b00), 0, 32'h310, 0, 1, 1, 32'h8877_6655, acc);
      checkOutput("full_after_pop_accept", acc, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 6'h0, 0, 0, 0, 1, 1, $urandom, acc);
      end
      checkOutput("full_drained_busy", busy, 0);

      // Misaligned word load traps without touching the bus.
      applyStimulus(1, mkOp(OPCAT_LD, 2'b11), 0, 32'h101, 0, 0, 0, 0, acc);
      checkOutput("mis_exc_valid", excValid, 1);
      checkOutput("mis_exc_addr", excAddr, 32'h101);
      checkOutput("mis_exc_st", excSt, 0);
      checkOutput("mis_no_req", busReq, 0);
      idleCycle(0);

      // Randomized traffic; responses only while loads are outstanding.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: cat = OPCAT_LD;
            4, 5, 6, 7: cat = OPCAT_ST;
            default:    cat = 4'($urandom_range(3, 15));
         endcase
         sc = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sc == 2'b01) a[0] = 1'b0;
            if (sc == 2'b11) a[1:0] = 2'b00;
         end
         applyStimulus($urandom_range(0, 3) != 0, mkOp(cat, sc), 1'($urandom_range(0, 1)), a, $urandom,
                       1'($urandom_range(0, 1)), (mQ.size() > 0) && ($urandom_range(0, 2) == 0),
                       $urandom, acc);
      end

      // Drain, then a spurious response sets the sticky error.
      guard = 0;
      while ((mQ.size() > 0 || mReq) && guard < 50) begin
         applyStimulus(0, 6'h0, 0, 0, 0, 1, mQ.size() > 0, $urandom, acc);
         guard++;
      end
      checkOutput("drain_done", busy, 0);
      applyStimulus(0, 6'h0, 0, 0, 0, 0, 1, 32'h1234_5678, acc);
      checkOutput("spurious_err", err, 1);
      checkOutput("spurious_no_ld", ldValid, 0);
      idleCycle(0);
      idleCycle(0);
      checkOutput("err_sticky", err, 1);

      // Reset in the middle of outstanding loads with a pending request.
      applyStimulus(1, mkOp(OPCAT_LD, 2'b11), 0, 32'h400, 0, 1, 0, 0, acc);
      applyStimulus(1, mkOp(OPCAT_LD, 2'b01), 1, 32'h406, 0, 0, 0, 0, acc);
      applyReset();
      checkOutput("post_rst_busy", busy, 0);
      applyStimulus(0, 6'h0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, acc);
      checkOutput("post_rst_spurious_err", err, 1);
      checkOutput("post_rst_no_ld", ldValid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
